// File: rtl/barrido_tabla.sv
`default_nettype none
// ============================================================================
//  Module      : barrido_tabla
//  Description : Exhaustive truth-table sweep checker. Drives all 32 values of
//                a 5-bit stimulus vector {A,B,C,D,E} into a logic block under
//                test. Each value is held for SETTLE cycles, and then the
//                reference outputs (res_a) are compared with the
//                alternate-form outputs (res_b). The module counts mismatches
//                and captures the first failing vector together with its
//                difference mask.
//
//  Parameters  : SETTLE          hold cycles per vector before compare (1..15)
//  Macro       : BARRIDO_STOP_EN when defined, the sweep ends at the first
//                                mismatch instead of covering all 32 vectors
//
//  Ports       : clk             rising-edge clock
//                reset           asynchronous active-low reset
//                start           sweep request, honoured only when idle
//                vec[4:0]        stimulus {A,B,C,D,E}, A = MSB
//                res_a[3:0]      reference outputs {f,g,h,i}
//                res_b[3:0]      alternate-form outputs {f_2,g_2,h_2,i_2}
//                busy            high while settling or comparing
//                done            one-cycle end-of-sweep pulse
//                ok              last sweep was mismatch-free
//                err_cnt[5:0]    mismatching vectors in last sweep (0..32)
//                first_err_valid a mismatch has been captured
//                first_err_vec   vector of the first mismatch
//                first_err_mask  res_a ^ res_b at the first mismatch
//
//  Revision    : 1.0  initial release
// ============================================================================
module barrido_tabla #(
    parameter int SETTLE = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic [4:0] vec,
    input  logic [3:0] res_a,
    input  logic [3:0] res_b,
    output logic       busy,
    output logic       done,
    output logic       ok,
    output logic [5:0] err_cnt,
    output logic       first_err_valid,
    output logic [4:0] first_err_vec,
    output logic [3:0] first_err_mask
);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_ESPERA  = 2'd1;
    localparam logic [1:0] c_COMPARA = 2'd2;
    localparam logic [1:0] c_FIN     = 2'd3;

    // The counter is loaded with SETTLE-1 and leaves ESPERA on reaching zero,
    // so ESPERA occupies exactly SETTLE cycles.
    localparam logic [3:0] c_RELOAD   = 4'(SETTLE - 1);
    localparam logic [4:0] c_VEC_LAST = 5'd31;

    logic [1:0] r_state;
    logic [3:0] r_cnt;
    logic [4:0] r_vec;
    logic       r_ok;
    logic [5:0] r_err_cnt;
    logic       r_first_valid;
    logic [4:0] r_first_vec;
    logic [3:0] r_first_mask;

    logic       w_mismatch;
    logic       w_last_vec;
    logic       w_end_sweep;
    logic       w_ok_next;

    assign w_mismatch = (res_a != res_b);
    assign w_last_vec = (r_vec == c_VEC_LAST);

`ifdef BARRIDO_STOP_EN
    assign w_end_sweep = w_last_vec || w_mismatch;
`else
    assign w_end_sweep = w_last_vec;
`endif

    // The verdict has to include the comparison made on the same edge that
    // enters FIN, because r_err_cnt does not yet reflect it at that point.
    assign w_ok_next = (r_err_cnt == 6'd0) && !w_mismatch;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= c_IDLE;
            r_cnt         <= 4'd0;
            r_vec         <= 5'd0;
            r_ok          <= 1'b0;
            r_err_cnt     <= 6'd0;
            r_first_valid <= 1'b0;
            r_first_vec   <= 5'd0;
            r_first_mask  <= 4'd0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_vec         <= 5'd0;
                        r_cnt         <= c_RELOAD;
                        r_err_cnt     <= 6'd0;
                        r_first_valid <= 1'b0;
                        r_ok          <= 1'b0;
                        r_state       <= c_ESPERA;
                    end
                end

                c_ESPERA: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= c_COMPARA;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end

                c_COMPARA: begin
                    if (w_mismatch) begin
                        r_err_cnt <= r_err_cnt + 6'd1;
                        if (!r_first_valid) begin
                            r_first_valid <= 1'b1;
                            r_first_vec   <= r_vec;
                            r_first_mask  <= res_a ^ res_b;
                        end
                    end
                    if (w_end_sweep) begin
                        // vec is left on the final vector and is not wrapped
                        // here; FIN returns it to zero.
                        r_ok    <= w_ok_next;
                        r_state <= c_FIN;
                    end else begin
                        r_vec   <= r_vec + 5'd1;
                        r_cnt   <= c_RELOAD;
                        r_state <= c_ESPERA;
                    end
                end

                c_FIN: begin
                    r_ok    <= (r_err_cnt == 6'd0);
                    r_vec   <= 5'd0;
                    r_state <= c_IDLE;
                end

                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign vec             = r_vec;
    assign busy            = (r_state == c_ESPERA) || (r_state == c_COMPARA);
    assign done            = (r_state == c_FIN);
    assign ok              = r_ok;
    assign err_cnt         = r_err_cnt;
    assign first_err_valid = r_first_valid;
    assign first_err_vec   = r_first_vec;
    assign first_err_mask  = r_first_mask;

endmodule
`default_nettype wire

// File: tb/tb_barrido_tabla.sv
`default_nettype none
// ============================================================================
//  Module      : tb_barrido_tabla
//  Description : Self-checking bench for barrido_tabla. Two instances are
//                used: index 0 with SETTLE=1 and index 1 with SETTLE=3. The
//                logic block under test is modelled by a table: res_a comes
//                from ra_tab[vec], and res_b = res_a ^ em_tab[vec]. Expected
//                results are derived from the table contents.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_barrido_tabla;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_s [2];
    logic [4:0] vec_s   [2];
    logic [3:0] ra_s    [2];
    logic [3:0] rb_s    [2];
    logic       busy_s  [2];
    logic       done_s  [2];
    logic       ok_s    [2];
    logic [5:0] ec_s    [2];
    logic       fev_s   [2];
    logic [4:0] fv_s    [2];
    logic [3:0] fm_s    [2];

    logic [3:0] ra_tab [32];
    logic [3:0] em_tab [32];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        barrido_tabla #(.SETTLE(g == 0 ? 1 : 3)) u_dut (
            .clk             (clk),
            .reset           (reset),
            .start           (start_s[g]),
            .vec             (vec_s[g]),
            .res_a           (ra_s[g]),
            .res_b           (rb_s[g]),
            .busy            (busy_s[g]),
            .done            (done_s[g]),
            .ok              (ok_s[g]),
            .err_cnt         (ec_s[g]),
            .first_err_valid (fev_s[g]),
            .first_err_vec   (fv_s[g]),
            .first_err_mask  (fm_s[g])
        );
        assign ra_s[g] = ra_tab[vec_s[g]];
        assign rb_s[g] = ra_tab[vec_s[g]] ^ em_tab[vec_s[g]];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic fill_tables(input int err_odds);
        for (int v = 0; v < 32; v++) begin
            ra_tab[v] = 4'($urandom);
            if (err_odds > 0 && $urandom_range(0, err_odds - 1) == 0)
                em_tab[v] = 4'($urandom_range(1, 15));
            else
                em_tab[v] = 4'd0;
        end
    endtask

    task automatic check_all_zero(input int w, input string pfx);
        check({pfx, "_vec"},   32'(vec_s[w]),  0);
        check({pfx, "_busy"},  32'(busy_s[w]), 0);
        check({pfx, "_done"},  32'(done_s[w]), 0);
        check({pfx, "_ok"},    32'(ok_s[w]),   0);
        check({pfx, "_ecnt"},  32'(ec_s[w]),   0);
        check({pfx, "_fev"},   32'(fev_s[w]),  0);
        check({pfx, "_fvec"},  32'(fv_s[w]),   0);
        check({pfx, "_fmask"}, 32'(fm_s[w]),   0);
    endtask

    // Runs one sweep on instance w. If inj is non-negative, an extra start
    // pulse is driven while vec equals inj; that pulse must have no effect.
    task automatic run_sweep(input int w, input int settle, input int inj);
        int visits, cnt, fvec, n, busyc;
        bit fvalid, stop_mode, injd;
        logic [3:0] fmask;
        // Reference model: walk the table in order.
        stop_mode = 1'b0;
`ifdef BARRIDO_STOP_EN
        stop_mode = 1'b1;
`endif
        visits = 0; cnt = 0; fvalid = 0; fvec = 0; fmask = 0;
        for (int v = 0; v < 32; v++) begin
            visits++;
            if (em_tab[v] != 4'd0) begin
                cnt++;
                if (!fvalid) begin
                    fvalid = 1; fvec = v; fmask = em_tab[v];
                end
                if (stop_mode) break;
            end
        end

        @(negedge clk);
        start_s[w] = 1'b1;
        @(posedge clk);
        #1;
        start_s[w] = 1'b0;
        check("accept_busy", 32'(busy_s[w]), 1);
        check("accept_ecnt", 32'(ec_s[w]), 0);
        check("accept_fev",  32'(fev_s[w]), 0);

        n = 0; busyc = 0; injd = 0;
        while (!done_s[w] && n < 700) begin
            if (busy_s[w]) busyc++;
            check("sweep_vec", 32'(vec_s[w]), 32'(n / (settle + 1)));
            if (inj >= 0 && !injd && vec_s[w] == 5'(inj)) begin
                start_s[w] = 1'b1;
                injd = 1;
            end
            @(posedge clk);
            #1;
            start_s[w] = 1'b0;
            n++;
        end
        check("latency",    32'(n), 32'(visits * (settle + 1)));
        check("busy_count", 32'(busyc), 32'(visits * (settle + 1)));
        check("fin_busy",   32'(busy_s[w]), 0);

        @(posedge clk);
        #1;
        check("done_pulse", 32'(done_s[w]), 0);
        check("post_busy",  32'(busy_s[w]), 0);
        check("post_vec",   32'(vec_s[w]), 0);
        check("ok",         32'(ok_s[w]), 32'(cnt == 0));
        check("err_cnt",    32'(ec_s[w]), 32'(cnt));
        check("first_valid", 32'(fev_s[w]), 32'(fvalid));
        if (fvalid) begin
            check("first_vec",  32'(fv_s[w]), 32'(fvec));
            check("first_mask", 32'(fm_s[w]), 32'(fmask));
        end
        // Results must hold while idle.
        repeat (3) @(posedge clk);
        #1;
        check("hold_ecnt", 32'(ec_s[w]), 32'(cnt));
        check("hold_ok",   32'(ok_s[w]), 32'(cnt == 0));
    endtask

    task automatic reset_mid(input int w);
        int n;
        @(negedge clk);
        start_s[w] = 1'b1;
        @(posedge clk);
        #1;
        start_s[w] = 1'b0;
        n = 0;
        while (vec_s[w] != 5'd10 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("vec10_reached", 32'(vec_s[w]), 10);
        check("vec10_busy",    32'(busy_s[w]), 1);
        #2;
        reset = 1'b0;
        #1;
        check_all_zero(w, "midrst");
        repeat (3) begin
            @(posedge clk);
            #1;
            check("midrst_no_done", 32'(done_s[w]), 0);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("idle_after_rst", 32'(busy_s[w]), 0);
        check("idle_vec",       32'(vec_s[w]), 0);
    endtask

    initial begin
        reset = 1'b0;
        start_s[0] = 1'b0;
        start_s[1] = 1'b0;
        fill_tables(0);

        repeat (3) @(posedge clk);
        #1;
        for (int w = 0; w < 2; w++) check_all_zero(w, "reset");
        @(negedge clk);
        reset = 1'b1;

        // Clean sweep, SETTLE=1.
        fill_tables(0);
        run_sweep(0, 1, -1);

        // Single mismatch on bit 0 at vec 13.
        fill_tables(0);
        em_tab[13] = 4'b0001;
        run_sweep(0, 1, -1);

        // Two mismatches, at vec 3 and vec 20.
        fill_tables(0);
        em_tab[3]  = 4'b0100;
        em_tab[20] = 4'b1010;
        run_sweep(0, 1, -1);

        // SETTLE=3 with an ignored start pulse at vec 7.
        fill_tables(0);
        run_sweep(1, 3, 7);

        // Abort during ESPERA, then sweep again from zero.
        fill_tables(0);
        em_tab[25] = 4'b1000;
        reset_mid(0);
        run_sweep(0, 1, -1);

        // Randomised tables on both instances.
        repeat (8) begin
            int w;
            w = int'($urandom_range(0, 1));
            fill_tables(int'($urandom_range(2, 12)));
            run_sweep(w, (w == 0) ? 1 : 3, int'($urandom_range(0, 40)) - 8);
        end

        // Every vector mismatching: err_cnt must reach 32 without saturating.
        fill_tables(0);
        for (int v = 0; v < 32; v++) em_tab[v] = 4'b1111;
        run_sweep(0, 1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
